slave_port_serdes: RTL and testbench

SLAVE_PORT_SERDES -- requirements
Module: slave_port_serdes

---
 rtl/slave_port_serdes.sv | 193 +++++++++++++++++++
 tb/tb_slave_port_serdes.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_port_serdes.sv
// Serial slave port: receives a bit-serial request header (address and
// burst count), serial write data, and drives a parallel memory interface.
// Read data is serialized back out LSB-first under master_ready flow control.
module slave_port_serdes #(
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_en,
    input  logic                write_en,
    input  logic                master_valid,
    input  logic                master_ready,
    input  logic                rx_address,
    input  logic                rx_data,
    input  logic                rx_burst,
    output logic                slave_ready,
    output logic                slave_valid,
    output logic                tx_data,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_wen,
    output logic                mem_ren,
    input  logic [DATA_LEN-1:0] mem_rdata,
    output logic                busy
);

    localparam int MAX_LEN = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        WMEM,
        RREQ,
        RWAIT,
        RDATA,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 dir_write;
    logic [ADDR_LEN-1:0]  addr_q;
    logic [BURST_LEN-1:0] beats_q;
    logic [DATA_LEN-1:0]  data_q;
    logic [CNT_W-1:0]     bit_cnt;

    logic start;
    logic hdr_last;
    logic data_last;
    logic last_beat;

    assign start     = master_valid && (write_en ^ read_en);
    assign hdr_last  = (bit_cnt == CNT_W'(ADDR_LEN - 1));
    assign data_last = (bit_cnt == CNT_W'(DATA_LEN - 1));
    // A received burst of 0 behaves like 1: both end after the current beat.
    assign last_beat = (beats_q <= BURST_LEN'(1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        state_nxt   = state;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        tx_data     = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wen     = 1'b0;
        mem_ren     = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                slave_ready = 1'b1;
                busy        = 1'b0;
                if (start) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                if (master_valid && hdr_last) begin
                    state_nxt = dir_write ? WDATA : RREQ;
                end
            end
            WDATA: begin
                slave_ready = 1'b1;
                if (master_valid && data_last) begin
                    state_nxt = WMEM;
                end
            end
            WMEM: begin
                mem_wen   = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = data_q;
                state_nxt = last_beat ? DONE : WDATA;
            end
            RREQ: begin
                mem_ren   = 1'b1;
                mem_addr  = addr_q;
                state_nxt = RWAIT;
            end
            RWAIT: begin
                state_nxt = RDATA;
            end
            RDATA: begin
                slave_valid = 1'b1;
                tx_data     = data_q[0];
                if (master_ready && data_last) begin
                    state_nxt = last_beat ? DONE : RREQ;
                end
            end
            DONE: begin
                slave_ready = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: header/data shift registers, bit counter, address and beat bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_write <= 1'b0;
            addr_q    <= '0;
            beats_q   <= '0;
            data_q    <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_write <= write_en;
                        addr_q    <= '0;
                        beats_q   <= '0;
                        bit_cnt   <= '0;
                    end
                end
                HDR: begin
                    if (master_valid) begin
                        addr_q <= {rx_address, addr_q[ADDR_LEN-1:1]};
                        if (32'(bit_cnt) < BURST_LEN) begin
                            beats_q <= {rx_burst, beats_q[BURST_LEN-1:1]};
                        end
                        bit_cnt <= hdr_last ? '0 : bit_cnt + CNT_W'(1);
                    end
                end
                WDATA: begin
                    if (master_valid) begin
                        data_q  <= {rx_data, data_q[DATA_LEN-1:1]};
                        bit_cnt <= data_last ? '0 : bit_cnt + CNT_W'(1);
                    end
                end
                WMEM: begin
                    addr_q <= addr_q + ADDR_LEN'(1);
                    if (!last_beat) begin
                        beats_q <= beats_q - BURST_LEN'(1);
                    end
                end
                RWAIT: begin
                    data_q  <= mem_rdata;
                    bit_cnt <= '0;
                end
                RDATA: begin
                    if (master_ready) begin
                        data_q  <= {1'b0, data_q[DATA_LEN-1:1]};
                        bit_cnt <= data_last ? '0 : bit_cnt + CNT_W'(1);
                        if (data_last) begin
                            addr_q <= addr_q + ADDR_LEN'(1);
                            if (!last_beat) begin
                                beats_q <= beats_q - BURST_LEN'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_port_serdes.sv
// Directed and randomized bench for slave_port_serdes with a memory model
// and a reference memory image maintained from intended transactions.
module tb_slave_port_serdes;

    localparam int AL = 12;
    localparam int DL = 8;
    localparam int BL = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          read_en, write_en, master_valid, master_ready;
    logic          rx_address, rx_data, rx_burst;
    logic          slave_ready, slave_valid, tx_data;
    logic [AL-1:0] mem_addr;
    logic [DL-1:0] mem_wdata;
    logic          mem_wen, mem_ren;
    logic [DL-1:0] mem_rdata = '0;
    logic          busy;

    int errors = 0;
    int checks = 0;

    int wen_total   = 0;
    int ren_total   = 0;
    int overlap_cnt = 0;

    bit [DL-1:0] phys_mem     [4096];
    bit          phys_written [4096];
    bit [DL-1:0] ref_mem      [4096];
    bit          ref_written  [4096];

    always #5 clk = ~clk;

    slave_port_serdes #(
        .ADDR_LEN (AL),
        .DATA_LEN (DL),
        .BURST_LEN(BL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .read_en     (read_en),
        .write_en    (write_en),
        .master_valid(master_valid),
        .master_ready(master_ready),
        .rx_address  (rx_address),
        .rx_data     (rx_data),
        .rx_burst    (rx_burst),
        .slave_ready (slave_ready),
        .slave_valid (slave_valid),
        .tx_data     (tx_data),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wen     (mem_wen),
        .mem_ren     (mem_ren),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    // Power-up memory contents; 0x010..0x012 hold 0x11, 0x22, 0x33
    function automatic logic [DL-1:0] init_val(int unsigned a);
        if (a >= 16 && a <= 18) return DL'((a - 15) * 17);
        return DL'((a * 37 + 11) ^ (a >> 4));
    endfunction

    function automatic logic [DL-1:0] ref_rd(int unsigned a);
        return ref_written[a] ? ref_mem[a] : init_val(a);
    endfunction

    // Memory model: one-cycle read latency, write on mem_wen
    always @(posedge clk) begin
        if (mem_ren) begin
            mem_rdata <= phys_written[mem_addr] ? phys_mem[mem_addr] : init_val(32'(mem_addr));
            ren_total <= ren_total + 1;
        end
        if (mem_wen) begin
            phys_mem[mem_addr]     <= mem_wdata;
            phys_written[mem_addr] <= 1'b1;
            wen_total              <= wen_total + 1;
        end
        if (mem_wen && mem_ren) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        master_valid = 1'b0;
        master_ready = 1'b0;
        read_en      = 1'b0;
        write_en     = 1'b0;
        rx_address   = 1'b0;
        rx_data      = 1'b0;
        rx_burst     = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(slave_ready), 1);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_oth"},   {slave_valid, tx_data, mem_wen, mem_ren, mem_addr, mem_wdata}, 0);
    endtask

    // Start request in IDLE, then shift the header with optional stalls
    task automatic send_header(input bit wr, input logic [AL-1:0] addr,
                               input logic [BL-1:0] burst, input int stall_pct);
        write_en     = wr;
        read_en      = !wr;
        master_valid = 1'b1;
        tick();
        check("hdr_ready", 32'(slave_ready), 0);
        for (int i = 0; i < AL;) begin
            // direction inputs are don't-care once the transfer has started
            write_en = 1'($urandom);
            read_en  = 1'($urandom);
            if (int'($urandom_range(99)) < stall_pct) begin
                master_valid = 1'b0;
                rx_address   = 1'($urandom);
                rx_burst     = 1'($urandom);
            end else begin
                master_valid = 1'b1;
                rx_address   = addr[i];
                rx_burst     = (i < BL) ? burst[i] : 1'b0;
                i++;
            end
            tick();
        end
        drive_idle();
    endtask

    // Serial write data for each beat; abort_beat/abort_bit >= 0 asserts reset there
    task automatic write_beats(input logic [AL-1:0] addr, input int beats,
                               input logic [DL-1:0] data[$], input int stall_pct,
                               input int abort_beat, input int abort_bit);
        logic [DL-1:0] word;
        for (int b = 0; b < beats; b++) begin
            word = data[b];
            check("wdata_ready", 32'(slave_ready), 1);
            for (int j = 0; j < DL;) begin
                if (b == abort_beat && j == abort_bit) begin
                    master_valid = 1'b1;
                    rx_data      = word[j];
                    reset        = 1'b1;
                    #1;
                    check_idle_outputs("abort");
                    tick();
                    tick();
                    reset = 1'b0;
                    drive_idle();
                    tick();
                    check_idle_outputs("post_abort");
                    return;
                end
                if (int'($urandom_range(99)) < stall_pct) begin
                    master_valid = 1'b0;
                    rx_data      = 1'($urandom);
                end else begin
                    master_valid = 1'b1;
                    rx_data      = word[j];
                    j++;
                end
                tick();
            end
            drive_idle();
            check("wr_wen",  32'(mem_wen), 1);
            check("wr_addr", 32'(mem_addr), 32'(AL'(addr + AL'(b))));
            check("wr_data", 32'(mem_wdata), 32'(word));
            ref_mem[AL'(addr + AL'(b))]     = word;
            ref_written[AL'(addr + AL'(b))] = 1'b1;
            tick();
        end
        check("wdone_ready", {slave_ready, busy, mem_wen}, 3'b110);
        tick();
        check_idle_outputs("widle");
    endtask

    // Per-beat read with optional random stalls and one forced stall in beat 0
    task automatic read_beats(input logic [AL-1:0] addr, input int beats, input int stall_pct,
                              input int stall_bit, input int stall_len);
        logic [DL-1:0] exp;
        logic [DL-1:0] got;
        int            n;
        for (int b = 0; b < beats; b++) begin
            check("rd_ren",  32'(mem_ren), 1);
            check("rd_addr", 32'(mem_addr), 32'(AL'(addr + AL'(b))));
            tick();
            check("rwait_valid", 32'(slave_valid), 0);
            tick();
            exp = ref_rd(32'(AL'(addr + AL'(b))));
            got = '0;
            for (int j = 0; j < DL; j++) begin
                n = 0;
                if (b == 0 && j == stall_bit) n = stall_len;
                else if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) n = int'($urandom_range(1, 3));
                for (int k = 0; k < n; k++) begin
                    master_ready = 1'b0;
                    tick();
                    check("bp_stable", {slave_valid, tx_data}, {1'b1, exp[j]});
                end
                check("rd_valid", 32'(slave_valid), 1);
                got[j]       = tx_data;
                master_ready = 1'b1;
                tick();
            end
            master_ready = 1'b0;
            check("rd_byte", 32'(got), 32'(exp));
        end
        check("rdone", {slave_ready, busy, slave_valid, mem_ren}, 4'b1100);
        tick();
        check_idle_outputs("ridle");
    endtask

    initial begin : stimulus
        logic [DL-1:0] wq[$];
        int            w0, r0, nb, burst;
        logic [AL-1:0] a;
        bit            wr;

        drive_idle();
        reset = 1'b1;
        #1;
        check_idle_outputs("in_reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("after_reset");

        // single write 0xA5 to 0x123
        w0 = wen_total;
        wq = '{8'hA5};
        send_header(1'b1, 12'h123, 12'd1, 0);
        write_beats(12'h123, 1, wq, 0, -1, -1);
        check("single_wen_count", 32'(wen_total - w0), 1);

        // burst read of 0x11, 0x22, 0x33 at 0x010
        r0 = ren_total;
        send_header(1'b0, 12'h010, 12'd3, 20);
        read_beats(12'h010, 3, 0, -1, 0);
        check("burst_ren_count", 32'(ren_total - r0), 3);

        // address wrap 0xFFF -> 0x000
        wq = '{8'h3C, 8'hC3};
        send_header(1'b1, 12'hFFF, 12'd2, 0);
        write_beats(12'hFFF, 2, wq, 0, -1, -1);
        send_header(1'b0, 12'hFFF, 12'd2, 0);
        read_beats(12'hFFF, 2, 0, -1, 0);

        // back-pressure: master_ready low 5 cycles at bit 3
        send_header(1'b0, 12'h123, 12'd1, 0);
        read_beats(12'h123, 1, 0, 3, 5);

        // reset during third data bit of beat 2
        w0 = wen_total;
        r0 = ren_total;
        wq = '{8'h5E, 8'hE5, 8'h77};
        send_header(1'b1, 12'h300, 12'd3, 0);
        write_beats(12'h300, 3, wq, 0, 1, 2);
        tick();
        check("abort_wen_count", 32'(wen_total - w0), 1);
        check("abort_ren_count", 32'(ren_total - r0), 0);
        send_header(1'b0, 12'h300, 12'd2, 0);
        read_beats(12'h300, 2, 0, -1, 0);

        // burst 0 is one beat
        w0 = wen_total;
        wq = '{8'h96};
        send_header(1'b1, 12'h040, 12'd0, 0);
        write_beats(12'h040, 1, wq, 0, -1, -1);
        check("burst0_wen_count", 32'(wen_total - w0), 1);

        // illegal start: both enables, then neither
        w0 = wen_total;
        r0 = ren_total;
        master_valid = 1'b1;
        read_en      = 1'b1;
        write_en     = 1'b1;
        tick();
        tick();
        check_idle_outputs("illegal_both");
        read_en  = 1'b0;
        write_en = 1'b0;
        tick();
        check_idle_outputs("illegal_none");
        drive_idle();
        tick();
        check("illegal_mem_count", 32'((wen_total - w0) + (ren_total - r0)), 0);

        // randomized transactions against the reference image
        for (int t = 0; t < 10; t++) begin
            wr    = 1'($urandom);
            a     = ($urandom_range(3) == 0) ? AL'(12'hFFE) : AL'($urandom);
            burst = int'($urandom_range(0, 4));
            nb    = (burst == 0) ? 1 : burst;
            w0    = wen_total;
            r0    = ren_total;
            send_header(wr, a, BL'(burst), 25);
            if (wr) begin
                wq = {};
                for (int k = 0; k < nb; k++) wq.push_back(DL'($urandom));
                write_beats(a, nb, wq, 25, -1, -1);
                check("rand_wen_count", 32'(wen_total - w0), 32'(nb));
            end else begin
                read_beats(a, nb, 25, -1, 0);
                check("rand_ren_count", 32'(ren_total - r0), 32'(nb));
            end
        end

        check("no_wen_ren_overlap", 32'(overlap_cnt), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
